// File: rtl/gf180mcu_fd_sc_mcu7t5v0__andn_pkg.sv
// rtl/gf180mcu_fd_sc_mcu7t5v0__andn_pkg.sv - shared constants and sizing helpers for the pipelined AND tree
//
// Purpose: width limits, counter width and the constant functions that size
// each 4-ary reduction level and place it inside the flattened stage vector.
// Ports: none (package).

package gf180mcu_fd_sc_mcu7t5v0__andn_pkg;

  localparam int MIN_WIDTH = 2;
  localparam int MAX_WIDTH = 64;
  localparam int CNT_W     = 8;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  // Number of 4-ary levels needed to reduce n bits to one; never below 1 so
  // even a 2-bit tree keeps one register stage.
  function automatic int clog4(input int n);
    int lv;
    int cap;
    lv  = 0;
    cap = 1;
    while (cap < n) begin
      cap = cap * 4;
      lv  = lv + 1;
    end
    if (lv == 0) lv = 1;
    return lv;
  endfunction

  // Bit count left after k reduction levels (k = 0 is the raw operand).
  function automatic int lvl_w(input int width, input int k);
    int w;
    w = width;
    for (int i = 0; i < k; i++) w = (w + 3) / 4;
    return w;
  endfunction

  // Offset of level k's output inside the packed vector of all stage outputs.
  // lvl_off(width, levels + 1) is therefore the total vector width.
  function automatic int lvl_off(input int width, input int k);
    int off;
    off = 0;
    for (int j = 1; j < k; j++) off = off + lvl_w(width, j);
    return off;
  endfunction

endpackage

// File: rtl/gf180mcu_fd_sc_mcu7t5v0__andn_pipe_lvl.sv
// rtl/gf180mcu_fd_sc_mcu7t5v0__andn_pipe_lvl.sv - one registered 4-ary AND level with valid and hold
//
// Purpose: ANDs groups of four input bits into one output bit each and
// registers the result together with a valid bit. A partial top group is
// padded with ones so it reduces only over the bits that exist.
// Ports:
//   clk       rising-edge clock
//   rn        asynchronous active-low reset (clears data and valid)
//   adv       1 = load new data/valid, 0 = hold both
//   in_data   IN_W bits from the previous level (or the operand)
//   in_valid  previous level valid
//   out_data  OUT_W = ceil(IN_W/4) registered AND results
//   out_valid registered valid

module gf180mcu_fd_sc_mcu7t5v0__andn_pipe_lvl #(
  parameter  int IN_W  = 4,
  localparam int OUT_W = (IN_W + 3) / 4
) (
  input  logic             clk,
  input  logic             rn,
  input  logic             adv,
  input  logic [IN_W-1:0]  in_data,
  input  logic             in_valid,
  output logic [OUT_W-1:0] out_data,
  output logic             out_valid
);

  logic [4*OUT_W-1:0] padded;
  logic [OUT_W-1:0]   red;
  logic [OUT_W-1:0]   data_d, data_q;
  logic               valid_d, valid_q;

  always_comb begin
    padded              = '1;
    padded[IN_W-1:0]    = in_data;
    red                 = '0;
    for (int g = 0; g < OUT_W; g++) begin
      red[g] = &padded[4*g +: 4];
    end
    data_d  = data_q;
    valid_d = valid_q;
    if (adv) begin
      data_d  = red;
      valid_d = in_valid;
    end
  end

  always_ff @(posedge clk or negedge rn) begin
    if (!rn) begin
      data_q  <= '0;
      valid_q <= 1'b0;
    end else begin
      data_q  <= data_d;
      valid_q <= valid_d;
    end
  end

  assign out_data  = data_q;
  assign out_valid = valid_q;

endmodule

// File: rtl/gf180mcu_fd_sc_mcu7t5v0__andn_pipe.sv
// rtl/gf180mcu_fd_sc_mcu7t5v0__andn_pipe.sv - pipelined WIDTH-input AND with handshake, sticky mode and fail counter
//
// Purpose: reduces A through LEVELS registered 4-ary AND levels. The whole
// pipeline moves together on adv = Z_READY | ~Z_VALID, so a stalled consumer
// freezes every stage. With ACCUM=1 the result is sticky across beats until
// CLR. FAIL_CNT counts delivered results that were 0, saturating at 255.
// Ports:
//   CLK       rising-edge clock
//   RN        asynchronous active-low reset
//   A         WIDTH operand bits
//   IN_VALID  A holds a beat
//   IN_READY  beat accepted this cycle (equals adv)
//   CLR       synchronous clear of accumulator and FAIL_CNT
//   Z         AND result of the oldest beat (sticky when ACCUM=1)
//   Z_VALID   Z holds a result
//   Z_READY   consumer takes Z this cycle
//   FAIL_CNT  number of delivered results with Z=0

module gf180mcu_fd_sc_mcu7t5v0__andn_pipe
  import gf180mcu_fd_sc_mcu7t5v0__andn_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int ACCUM = 0
) (
  input  logic             CLK,
  input  logic             RN,
  input  logic [WIDTH-1:0] A,
  input  logic             IN_VALID,
  output logic             IN_READY,
  input  logic             CLR,
  output logic             Z,
  output logic             Z_VALID,
  input  logic             Z_READY,
  output logic [CNT_W-1:0] FAIL_CNT
);

  localparam int LEVELS   = clog4(WIDTH);
  localparam int TOT_W    = lvl_off(WIDTH, LEVELS + 1);
  localparam int LAST_OFF = lvl_off(WIDTH, LEVELS);

  if (WIDTH < MIN_WIDTH || WIDTH > MAX_WIDTH) begin : g_bad_width
    $error("andn_pipe: WIDTH %0d outside %0d..%0d", WIDTH, MIN_WIDTH, MAX_WIDTH);
  end
  if (ACCUM != 0 && ACCUM != 1) begin : g_bad_accum
    $error("andn_pipe: ACCUM must be 0 or 1, got %0d", ACCUM);
  end

  // All level outputs packed back to back; level k sits at lvl_off(WIDTH, k).
  logic [TOT_W-1:0]  stg_data;
  logic [LEVELS:1]   stg_valid;
  logic              adv;
  logic              last_data;
  logic              z_int;
  logic              out_xfer;
  logic              z0_xfer;
  logic              acc_d, acc_q;
  logic [CNT_W-1:0]  fail_cnt_d, fail_cnt_q;

  assign adv      = Z_READY | ~Z_VALID;
  assign IN_READY = adv;

  for (genvar k = 1; k <= LEVELS; k++) begin : g_lvl
    localparam int IW  = lvl_w(WIDTH, k - 1);
    localparam int OW  = lvl_w(WIDTH, k);
    localparam int OFF = lvl_off(WIDTH, k);

    logic [IW-1:0] d_in;
    logic          v_in;

    if (k == 1) begin : g_first
      assign d_in = A;
      assign v_in = IN_VALID;
    end else begin : g_next
      assign d_in = stg_data[lvl_off(WIDTH, k - 1) +: IW];
      assign v_in = stg_valid[k-1];
    end

    gf180mcu_fd_sc_mcu7t5v0__andn_pipe_lvl #(
      .IN_W (IW)
    ) u_lvl (
      .clk       (CLK),
      .rn        (RN),
      .adv       (adv),
      .in_data   (d_in),
      .in_valid  (v_in),
      .out_data  (stg_data[OFF +: OW]),
      .out_valid (stg_valid[k])
    );
  end

  assign last_data = stg_data[LAST_OFF];
  assign Z_VALID   = stg_valid[LEVELS];

  // Both operands are registers, so Z is a clean 0 straight out of reset.
  assign z_int    = (ACCUM != 0) ? (acc_q & last_data) : last_data;
  assign Z        = z_int;
  assign out_xfer = Z_VALID & Z_READY;
  assign z0_xfer  = out_xfer & ~z_int;

  // CLR acts before the transfer in the same cycle: the accumulator restarts
  // from the beat being delivered, and a failing beat becomes the first count.
  always_comb begin
    acc_d      = acc_q;
    fail_cnt_d = fail_cnt_q;
    if (CLR) begin
      acc_d      = out_xfer ? last_data : 1'b1;
      fail_cnt_d = z0_xfer ? CNT_W'(1) : '0;
    end else begin
      if (out_xfer) acc_d = z_int;
      if (z0_xfer && fail_cnt_q != CNT_MAX) fail_cnt_d = fail_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge CLK or negedge RN) begin
    if (!RN) begin
      acc_q      <= 1'b1;
      fail_cnt_q <= '0;
    end else begin
      acc_q      <= acc_d;
      fail_cnt_q <= fail_cnt_d;
    end
  end

  assign FAIL_CNT = fail_cnt_q;

endmodule

// File: tb/tb_gf180mcu_fd_sc_mcu7t5v0__andn_pipe.sv
// tb/tb_gf180mcu_fd_sc_mcu7t5v0__andn_pipe.sv - scoreboard bench for the pipelined AND

module tb_gf180mcu_fd_sc_mcu7t5v0__andn_pipe;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rn0, rn1;
  logic [15:0] a0, a1;
  logic [4:0]  a2;
  logic        v0, v1, v2, clr0, clr1, clr2, zr0, zr1, zr2;
  logic        rdy0, rdy1, rdy2, z0, z1, z2, zv0, zv1, zv2;
  logic [7:0]  fc0, fc1, fc2;

  int n_assert = 0;
  int n_fail   = 0;
  logic q0[$];
  logic q1[$];
  logic q2[$];

  gf180mcu_fd_sc_mcu7t5v0__andn_pipe #(.WIDTH(16), .ACCUM(0)) u_w16 (
    .CLK(clk), .RN(rn0), .A(a0), .IN_VALID(v0), .IN_READY(rdy0), .CLR(clr0),
    .Z(z0), .Z_VALID(zv0), .Z_READY(zr0), .FAIL_CNT(fc0));

  gf180mcu_fd_sc_mcu7t5v0__andn_pipe #(.WIDTH(16), .ACCUM(1)) u_acc (
    .CLK(clk), .RN(rn1), .A(a1), .IN_VALID(v1), .IN_READY(rdy1), .CLR(clr1),
    .Z(z1), .Z_VALID(zv1), .Z_READY(zr1), .FAIL_CNT(fc1));

  gf180mcu_fd_sc_mcu7t5v0__andn_pipe #(.WIDTH(5), .ACCUM(0)) u_w5 (
    .CLK(clk), .RN(rn1), .A(a2), .IN_VALID(v2), .IN_READY(rdy2), .CLR(clr2),
    .Z(z2), .Z_VALID(zv2), .Z_READY(zr2), .FAIL_CNT(fc2));

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Offer one beat to u_w16 and wait (bounded) for IN_READY before it moves.
  task automatic send0(input logic [15:0] a);
    logic ok;
    ok = 1'b0;
    a0 = a;
    v0 = 1'b1;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (rdy0) begin
        ok = 1'b1;
        break;
      end
    end
    chk("u0_in_ready_wait", 16'(ok), 16'd1);
    if (ok) q0.push_back(&a);
    tick();
    v0 = 1'b0;
  endtask

  always @(negedge clk) begin
    if (zv0 && zr0) begin
      chk("u0_pending", 16'(q0.size() > 0), 16'd1);
      if (q0.size() > 0) chk("u0_z", 16'(z0), 16'(q0.pop_front()));
    end
  end

  always @(negedge clk) begin
    if (zv1 && zr1) begin
      chk("u1_pending", 16'(q1.size() > 0), 16'd1);
      if (q1.size() > 0) chk("u1_z", 16'(z1), 16'(q1.pop_front()));
    end
  end

  always @(negedge clk) begin
    if (zv2 && zr2) begin
      chk("u2_pending", 16'(q2.size() > 0), 16'd1);
      if (q2.size() > 0) chk("u2_z", 16'(z2), 16'(q2.pop_front()));
    end
  end

  initial begin
    logic [4:0] w5 [5];
    w5 = '{5'h1F, 5'h0F, 5'h1E, 5'h1F, 5'h10};

    rn0 = 1'b1; rn1 = 1'b1;
    a0 = '0; a1 = '0; a2 = '0;
    v0 = 0; v1 = 0; v2 = 0;
    clr0 = 0; clr1 = 0; clr2 = 0;
    zr0 = 0; zr1 = 0; zr2 = 0;
    #1;
    rn0 = 1'b0; rn1 = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_zv", 16'(zv0), 16'd0);
    chk("rst_z", 16'(z0), 16'd0);
    chk("rst_fc", 16'(fc0), 16'd0);
    chk("rst_rdy", 16'(rdy0), 16'd1);
    chk("rst_acc_z", 16'(z1), 16'd0);
    @(negedge clk);
    rn0 = 1'b1; rn1 = 1'b1;
    #1;
    chk("rdy_after_rst", 16'(rdy0), 16'd1);
    tick();

    // Basic stream with latency check
    zr0 = 1'b1;
    send0(16'hFFFF);
    chk("lat_zv_early", 16'(zv0), 16'd0);
    send0(16'hFFFE);
    chk("lat_zv_on", 16'(zv0), 16'd1);
    send0(16'hFFFF);
    repeat (4) tick();
    chk("fc_basic", 16'(fc0), 16'd1);

    // CLR with nothing delivered
    clr0 = 1'b1; tick(); clr0 = 1'b0;
    chk("fc_clr_idle", 16'(fc0), 16'd0);

    // Stall: consumer not ready while beats pile up
    zr0 = 1'b0;
    send0(16'hFFFF);
    send0(16'h0000);
    a0 = 16'hFFFF; v0 = 1'b1;
    @(negedge clk);
    chk("stall_rdy", 16'(rdy0), 16'd0);
    chk("stall_zv", 16'(zv0), 16'd1);
    chk("stall_head", 16'(z0), 16'd1);
    repeat (3) tick();
    chk("stall_rdy_hold", 16'(rdy0), 16'd0);
    zr0 = 1'b1;
    send0(16'hFFFF);
    repeat (4) tick();
    chk("stall_drained", 16'(q0.size()), 16'd0);
    chk("stall_fc", 16'(fc0), 16'd1);

    // Saturation, then CLR coinciding with a failing delivery
    repeat (300) send0(16'h0000);
    repeat (4) tick();
    chk("fc_sat", 16'(fc0), 16'd255);
    send0(16'h0000);
    tick();
    chk("clr_beat_zv", 16'(zv0), 16'd1);
    clr0 = 1'b1; tick(); clr0 = 1'b0;
    chk("fc_clr_fail", 16'(fc0), 16'd1);

    // Reset with two beats in flight
    send0(16'hFFFF);
    send0(16'h0000);
    rn0 = 1'b0;
    #1;
    chk("rst_mid_zv", 16'(zv0), 16'd0);
    chk("rst_mid_fc", 16'(fc0), 16'd0);
    chk("rst_mid_rdy", 16'(rdy0), 16'd1);
    q0.delete();
    @(negedge clk);
    rn0 = 1'b1;
    repeat (5) tick();
    chk("no_stale", 16'(zv0), 16'd0);
    send0(16'hFFFE);
    chk("post_rst_early", 16'(zv0), 16'd0);
    tick();
    chk("post_rst_zv", 16'(zv0), 16'd1);
    repeat (3) tick();

    // Sticky accumulate with CLR on the third delivery
    zr1 = 1'b1;
    a1 = 16'hFFFF; v1 = 1'b1; q1.push_back(1'b1); tick();
    a1 = 16'h7FFF;            q1.push_back(1'b0); tick();
    a1 = 16'hFFFF;            q1.push_back(1'b0); tick();
    a1 = 16'hFFFF;            q1.push_back(1'b1); tick();
    v1 = 1'b0; clr1 = 1'b1;
    chk("acc_third_zv", 16'(zv1), 16'd1);
    tick();
    clr1 = 1'b0;
    repeat (3) tick();
    chk("acc_fc", 16'(fc1), 16'd1);
    chk("acc_drained", 16'(q1.size()), 16'd0);

    // Five-bit operand exercises partial-group padding
    zr2 = 1'b1;
    for (int i = 0; i < 5; i++) begin
      a2 = w5[i]; v2 = 1'b1; q2.push_back(&w5[i]);
      tick();
    end
    v2 = 1'b0;
    repeat (4) tick();
    chk("w5_drained", 16'(q2.size()), 16'd0);
    chk("w5_fc", 16'(fc2), 16'd3);
    chk("u0_drained", 16'(q0.size()), 16'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "timeout");
  end

endmodule
